cache_controller: RTL and testbench

//  Control FSM sitting directly upstream of memory_datapath: takes CPU load/store requests

---
 rtl/cache_controller.sv | 143 ++++++++++++++
 tb/tb_cache_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - cache control FSM: hits, dirty write-back, line fill, hit/miss stats
//
// Purpose: sequences CPU load/store requests against the cache and a fixed-latency
// main memory. A hit completes in the request cycle. A miss stalls the CPU through
// an optional write-back (WB), a memory read (ALLOC) and a one-cycle line fill (FILL).
// The request is then re-evaluated in IDLE and hits.
//
// Ports:
//   clk, rst_b                  clock, asynchronous active-low reset
//   mem_read, mem_write         CPU request (write wins if both are set), held while stall=1
//   byte_access                 store writes a single byte
//   hit, dirty_bit              cache status, sampled in IDLE only
//   cache_we, cache_in_select   cache write enable; data source (1: CPU, 0: memory)
//   mem_in_select, is_byte      memory address source (1: victim); byte write to cache
//   mem_we, stall               main-memory write enable; CPU hold
//   hit_count, miss_count       wrapping statistics counters
module cache_controller #(
  parameter int MEM_LATENCY = 4,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              byte_access,
  input  logic              hit,
  input  logic              dirty_bit,
  output logic              cache_we,
  output logic              cache_in_select,
  output logic              mem_in_select,
  output logic              is_byte,
  output logic              mem_we,
  output logic              stall,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC, S_FILL} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_refill, w_refill_next;
  logic            w_hit_inc, w_miss_inc;
  logic            w_req, w_is_write, w_lat_done;
  logic            w_cache_we, w_cache_in_select, w_mem_in_select, w_is_byte, w_mem_we, w_stall;
  logic [STAT_W-1:0] r_hit_count, r_miss_count;

  assign w_req      = mem_read | mem_write;
  assign w_is_write = mem_write;
  assign w_lat_done = (r_cnt == CW'(MEM_LATENCY - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_refill     <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_next;
      r_refill <= w_refill_next;
      if (w_hit_inc)  r_hit_count  <= r_hit_count + 1'b1;
      if (w_miss_inc) r_miss_count <= r_miss_count + 1'b1;
    end
  end

  always_comb begin
    w_next            = r_state;
    w_cnt_next        = r_cnt;
    w_refill_next     = r_refill;
    w_hit_inc         = 1'b0;
    w_miss_inc        = 1'b0;
    w_cache_we        = 1'b0;
    w_cache_in_select = 1'b0;
    w_mem_in_select   = 1'b0;
    w_is_byte         = 1'b0;
    w_mem_we          = 1'b0;
    w_stall           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req && hit) begin
          if (w_is_write) begin
            w_cache_we        = 1'b1;
            w_cache_in_select = 1'b1;
            w_is_byte         = byte_access;
          end
          // A hit that follows our own refill was already counted as a miss.
          w_hit_inc     = !r_refill;
          w_refill_next = 1'b0;
        end else if (w_req) begin
          w_stall       = 1'b1;
          w_miss_inc    = 1'b1;
          w_refill_next = 1'b1;
          w_cnt_next    = '0;
          w_next        = dirty_bit ? S_WB : S_ALLOC;
        end else begin
          // Request dropped during a miss: forget the refill so nothing is counted.
          w_refill_next = 1'b0;
        end
      end
      S_WB: begin
        w_mem_in_select = 1'b1;
        w_mem_we        = 1'b1;
        w_stall         = 1'b1;
        if (w_lat_done) begin
          w_cnt_next = '0;
          w_next     = S_ALLOC;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_ALLOC: begin
        w_stall = 1'b1;
        if (w_lat_done) begin
          w_cnt_next = '0;
          w_next     = S_FILL;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_FILL: begin
        w_cache_we = 1'b1;
        w_stall    = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Gate with reset so a held request cannot raise Mealy outputs while in reset.
  assign cache_we        = w_cache_we        & rst_b;
  assign cache_in_select = w_cache_in_select & rst_b;
  assign mem_in_select   = w_mem_in_select   & rst_b;
  assign is_byte         = w_is_byte         & rst_b;
  assign mem_we          = w_mem_we          & rst_b;
  assign stall           = w_stall           & rst_b;
  assign hit_count       = r_hit_count;
  assign miss_count      = r_miss_count;

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed self-checking bench for cache_controller
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic mem_read = 0, mem_write = 0, byte_access = 0, hit = 0, dirty_bit = 0;
  logic cache_we, cache_in_select, mem_in_select, is_byte, mem_we, stall;
  logic [31:0] hit_count, miss_count;

  logic w_mem_read = 0, w_mem_write = 0, w_byte_access = 0, w_hit = 0, w_dirty_bit = 0;
  logic w_cache_we, w_cache_in_select, w_mem_in_select, w_is_byte, w_mem_we, w_stall;
  logic [1:0] w_hit_count, w_miss_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cache_controller #(.MEM_LATENCY(4), .STAT_W(32)) u_dut (
    .clk(clk), .rst_b(rst_b), .mem_read(mem_read), .mem_write(mem_write),
    .byte_access(byte_access), .hit(hit), .dirty_bit(dirty_bit),
    .cache_we(cache_we), .cache_in_select(cache_in_select), .mem_in_select(mem_in_select),
    .is_byte(is_byte), .mem_we(mem_we), .stall(stall),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_controller #(.MEM_LATENCY(4), .STAT_W(2)) u_wrap (
    .clk(clk), .rst_b(rst_b), .mem_read(w_mem_read), .mem_write(w_mem_write),
    .byte_access(w_byte_access), .hit(w_hit), .dirty_bit(w_dirty_bit),
    .cache_we(w_cache_we), .cache_in_select(w_cache_in_select), .mem_in_select(w_mem_in_select),
    .is_byte(w_is_byte), .mem_we(w_mem_we), .stall(w_stall),
    .hit_count(w_hit_count), .miss_count(w_miss_count)
  );

  // {cache_we, cache_in_select, mem_in_select, is_byte, mem_we, stall}
  function automatic logic [5:0] outs();
    return {cache_we, cache_in_select, mem_in_select, is_byte, mem_we, stall};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one miss and checks every stalled cycle against a hand-built sequence.
  task automatic run_miss(input logic is_wr, input logic dirty, input logic [31:0] exp_stall);
    logic [5:0] exp_v;
    int         n_stall;
    logic       done;
    mem_read  = !is_wr;
    mem_write = is_wr;
    byte_access = 1'b0;
    hit       = 1'b0;
    dirty_bit = dirty;
    n_stall   = 0;
    done      = 1'b0;
    #1;
    for (int k = 0; k < 30; k++) begin
      if (!done) begin
        if (!stall) begin
          done = 1'b1;
        end else begin
          if (k == 0)                               exp_v = 6'b000001;
          else if (dirty && k <= 4)                 exp_v = 6'b001011;
          else if (k == int'(exp_stall) - 1)        exp_v = 6'b100001;
          else                                      exp_v = 6'b000001;
          check($sformatf("miss_cyc%0d", k), {26'd0, outs()}, {26'd0, exp_v});
          n_stall++;
          step();
          hit = 1'b1;   // line is present from now on; ignored until back in IDLE
          dirty_bit = 1'b0;
          #1;
        end
      end
    end
    check("miss_stall_len", n_stall, exp_stall);
    check("miss_complete", {26'd0, outs()}, is_wr ? 32'b110000 : 32'b0);
    step();
    mem_read = 0; mem_write = 0; hit = 0;
    #1;
  endtask

  initial begin
    logic any_we;
    // reset state
    #1;
    check("reset_outs", {26'd0, outs()}, 32'd0);
    step();
    step();
    rst_b = 1'b1;

    // 1. reset in the middle of a write-back
    mem_write = 1; hit = 0; dirty_bit = 1;
    #1;
    check("t1_idle_miss", {26'd0, outs()}, 32'b000001);
    step();
    check("t1_wb_outs", {26'd0, outs()}, 32'b001011);
    check("t1_miss_cnt", miss_count, 32'd1);
    step();
    rst_b = 1'b0;
    #1;
    check("t1_async_outs", {26'd0, outs()}, 32'd0);
    check("t1_async_miss", miss_count, 32'd0);
    mem_write = 0; dirty_bit = 0;
    step();
    rst_b = 1'b1;
    any_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      any_we = any_we | mem_we | stall;
    end
    check("t1_no_mem_we", {31'd0, any_we}, 32'd0);
    check("t1_hit_cnt", hit_count, 32'd0);

    // 2. read hit
    mem_read = 1; hit = 1;
    #1;
    check("t2_outs", {26'd0, outs()}, 32'd0);
    step();
    mem_read = 0; hit = 0;
    #1;
    check("t2_hit_cnt", hit_count, 32'd1);

    // 3. byte write hit
    mem_write = 1; byte_access = 1; hit = 1;
    #1;
    check("t3_outs", {26'd0, outs()}, 32'b110100);
    step();
    mem_write = 0; byte_access = 0; hit = 0;
    #1;
    check("t3_after", {26'd0, outs()}, 32'd0);
    check("t3_hit_cnt", hit_count, 32'd2);

    // 4. clean read miss: 6 stall cycles
    run_miss(1'b0, 1'b0, 32'd6);
    check("t4_miss_cnt", miss_count, 32'd1);
    check("t4_hit_cnt", hit_count, 32'd2);

    // 5. dirty write miss: 10 stall cycles, then the store
    run_miss(1'b1, 1'b1, 32'd10);
    check("t5_miss_cnt", miss_count, 32'd2);
    check("t5_hit_cnt", hit_count, 32'd2);

    // request dropped after the miss cycle: line still fills, refill flag clears
    mem_read = 1; hit = 0; dirty_bit = 0;
    step();
    mem_read = 0;
    repeat (5) step();
    check("drop_fill_done", {26'd0, outs()}, 32'd0);
    step();
    mem_read = 1; hit = 1;
    step();
    mem_read = 0; hit = 0;
    #1;
    check("drop_hit_cnt", hit_count, 32'd3);
    check("drop_miss_cnt", miss_count, 32'd3);

    // 6. read+write together is a write; 2-bit counter wraps after 4 hits
    w_mem_read = 1; w_mem_write = 1; w_hit = 1;
    #1;
    check("t6_we", {30'd0, w_cache_we, w_cache_in_select}, 32'b11);
    check("t6_stall", {31'd0, w_stall}, 32'd0);
    repeat (3) step();
    check("t6_cnt3", {30'd0, w_hit_count}, 32'd3);
    step();
    check("t6_wrap", {30'd0, w_hit_count}, 32'd0);
    w_mem_read = 0; w_mem_write = 0; w_hit = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
